// File: rtl/pll_clock_divider.sv
// Glitch-free programmable integer divider for the PLL output phase, with a
// settle window after enable and period-aligned ratio changes and shutdown.
module pll_clock_divider #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             ready,
  output logic             period_strobe
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             clk_q, clk_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] n_req;
  logic             wrap;
  logic             active;

  assign n_req  = (div < WIDTH'(2)) ? WIDTH'(2) : div;
  assign wrap   = (cnt_q == (n_q - WIDTH'(1)));
  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  assign period_strobe = active && wrap;
  assign clk_out       = clk_q;
  assign ready         = ready_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    clk_d    = clk_q;
    ready_d  = ready_q;
    case (state_q)
      S_OFF: begin
        cnt_d    = '0;
        clk_d    = 1'b0;
        ready_d  = 1'b0;
        settle_d = '0;
        if (enable) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!enable) begin
          state_d  = S_OFF;
          settle_d = '0;
        end else if (settle_q == SW'(SETTLE_CYCLES)) begin
          state_d  = S_RUN;
          settle_d = '0;
          n_d      = n_req;
          cnt_d    = '0;
          clk_d    = 1'b1;
          ready_d  = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: begin
        // RUN and DRAIN share the counter; the ratio only reloads at a wrap so
        // the high phase is always computed against the period's own n.
        if (wrap) begin
          cnt_d = '0;
          n_d   = n_req;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        clk_d   = (cnt_d < (n_d >> 1));
        ready_d = 1'b1;
        if (state_q == S_RUN) begin
          if (!enable) state_d = S_DRAIN;
        end else if (wrap) begin
          if (enable) begin
            state_d = S_RUN;
          end else begin
            state_d = S_OFF;
            cnt_d   = '0;
            clk_d   = 1'b0;
            ready_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_OFF;
      settle_q <= '0;
      cnt_q    <= '0;
      n_q      <= WIDTH'(2);
      clk_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      clk_q    <= clk_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_pll_clock_divider.sv
// Directed bench for pll_clock_divider: ratio table plus start, settle-abort,
// drain, ratio-change and reset corner sequences.
module tb_pll_clock_divider;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] div = 4'd4;
  logic       clk_out, ready, period_strobe;

  int vectors = 0;
  int miscompares = 0;

  pll_clock_divider #(.WIDTH(4), .SETTLE_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .enable(enable), .div(div),
    .clk_out(clk_out), .ready(ready), .period_strobe(period_strobe)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] d;
    int         hi;
    int         lo;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string name);
    int seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (period_strobe) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) check({name, " strobe timeout"}, 0, 1);
  endtask

  task automatic wait_rise(output int zeros);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (clk_out) break;
      zeros++;
    end
  endtask

  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clk_out) hi++;
      else lo++;
      if (period_strobe) break;
    end
  endtask

  initial begin
    int zeros, hi, lo, n, any_hi, rdy;
    logic [15:0] pat;

    vt[0] = '{4'd4, 2, 2};
    vt[1] = '{4'd5, 2, 3};
    vt[2] = '{4'd0, 1, 1};
    vt[3] = '{4'd1, 1, 1};
    vt[4] = '{4'd15, 7, 8};
    vt[5] = '{4'd2, 1, 1};
    vt[6] = '{4'd6, 3, 3};
    vt[7] = '{4'd8, 4, 4};

    // Reset and first start
    repeat (3) tick();
    check("reset clk_out", int'(clk_out), 0);
    check("reset ready", int'(ready), 0);
    check("reset strobe", int'(period_strobe), 0);
    reset = 1'b0;
    div = 4'd4;
    enable = 1'b1;
    wait_rise(zeros);
    check("start zeros", zeros, 65);
    check("start ready", int'(ready), 1);
    pat = '0;
    pat = {pat[14:0], clk_out};
    for (int i = 0; i < 7; i++) begin
      tick();
      pat = {pat[14:0], clk_out};
    end
    check("start pattern", int'(pat[7:0]), 8'b11001100);

    // Ratio table
    for (int i = 0; i < 8; i++) begin
      div = vt[i].d;
      wait_strobe("vec");
      measure(hi, lo);
      check($sformatf("vec%0d div=%0d high", i, vt[i].d), hi, vt[i].hi);
      check($sformatf("vec%0d div=%0d low", i, vt[i].d), lo, vt[i].lo);
    end

    // Ratio change mid-period
    div = 4'd4;
    wait_strobe("chg");
    wait_strobe("chg");
    n = 0;
    tick(); n++;
    tick(); n++;
    div = 4'd6;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (period_strobe) break;
    end
    check("chg current period", n, 4);
    measure(hi, lo);
    check("chg next high", hi, 3);
    check("chg next low", lo, 3);

    // Drain: enable drops at cnt=1 of a 6-cycle period
    wait_strobe("drain");
    tick();
    tick();
    enable = 1'b0;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = {pat[14:0], clk_out};
    end
    check("drain pattern", int'(pat[3:0]), 4'b1000);
    check("drain wrap strobe", int'(period_strobe), 1);
    check("drain ready before wrap", int'(ready), 1);
    tick();
    check("drain off clk_out", int'(clk_out), 0);
    check("drain off ready", int'(ready), 0);
    tick();
    check("drain off strobe", int'(period_strobe), 0);

    // Drain cancelled by re-raising enable before the wrap
    enable = 1'b1;
    wait_rise(zeros);
    check("restart zeros", zeros, 65);
    wait_strobe("redrain");
    tick();
    tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    pat = '0;
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat = {pat[14:0], clk_out};
      rdy += int'(ready);
    end
    check("redrain pattern", int'(pat[9:0]), 10'b0001110001);
    check("redrain ready", rdy, 10);

    // Settle abort at settle count 30
    reset = 1'b1;
    tick();
    reset = 1'b0;
    any_hi = 0;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      any_hi |= int'(clk_out) | int'(ready);
    end
    enable = 1'b0;
    tick();
    any_hi |= int'(clk_out) | int'(ready);
    repeat (3) begin
      tick();
      any_hi |= int'(clk_out) | int'(ready);
    end
    check("abort no output", any_hi, 0);
    enable = 1'b1;
    wait_rise(zeros);
    check("abort resettle zeros", zeros, 65);

    // Reset during a high phase with div=8
    div = 4'd8;
    wait_strobe("rst");
    wait_strobe("rst");
    tick();
    tick();
    check("rst pre high", int'(clk_out), 1);
    reset = 1'b1;
    tick();
    check("rst clk_out", int'(clk_out), 0);
    check("rst ready", int'(ready), 0);
    check("rst strobe", int'(period_strobe), 0);
    reset = 1'b0;
    wait_rise(zeros);
    check("rst resettle zeros", zeros, 65);
    check("rst ready rise", int'(ready), 1);
    wait_strobe("rst2");
    measure(hi, lo);
    check("rst div8 high", hi, 4);
    check("rst div8 low", lo, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pll_clock_divider.md
# pll_clock_divider

Programmable, glitch-free integer divider that runs on the DCO/PLL output phase `clockp[0]` and produces the divided core clock for the clocking block. It holds its output low for a fixed settle window after enable so the ring oscillator can stabilise. It retimes ratio changes to period boundaries, and on disable it drains the current period, so the output never emits a runt pulse except under reset.

## Interface
Parameters:
- `WIDTH`, 4: width of the ratio input; maximum divide ratio is 2^WIDTH-1.
- `SETTLE_CYCLES`, 64: input-clock cycles the output is held low after enable before division starts (≥1).

Ports:
- `clock`  in  1  PLL output clock (`clockp[0]`); all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  start/stop request; level-sensitive, sampled every edge.
- `div`  in  WIDTH  requested divide ratio N; values 0 and 1 saturate to 2.
- `clk_out`  out  1  registered divided clock.
- `ready`  out  1  high while the divider is emitting clock (RUN or DRAIN).
- `period_strobe`  out  1  one-cycle pulse marking the last input cycle of each output period.

## Operation
- Single clock; reset is synchronous and active-high (`clock`, `reset`).
- Internal state: FSM {OFF, SETTLE, RUN, DRAIN}, settle counter, period counter `cnt`, and shadow ratio `n` (WIDTH bits).
- Ratio saturation: `n_req` = (`div` < 2) ? 2 : `div`.
- **OFF:** `cnt`=0, `clk_out`=0, `ready`=0.
  - If `enable`=1, go to SETTLE and clear the settle counter.
- **SETTLE:** increment the settle counter each edge.
  - If `enable`=0, go to OFF immediately; the counter is cleared.
  - After exactly `SETTLE_CYCLES` edges in SETTLE, go to RUN. On that edge: `n`<=`n_req`, `cnt`<=0, `clk_out`<=1, `ready`<=1.
- **RUN:**
  - `cnt` <= (`cnt`==`n`-1) ? 0 : `cnt`+1.
  - `clk_out` <= (next `cnt` < floor(`n`/2)).
  - Result: high for floor(n/2) input cycles, low for n-floor(n/2). Duty is 50% for even n; odd n is low-biased.
- **Wrap edge** (`cnt`==`n`-1):
  - `period_strobe`=1 during that cycle (combinational from state, registered-input only).
  - `n`<=`n_req`, so a new ratio takes effect from the next period's first cycle.
  - A `div` change mid-period has no effect on the current period.
- **DRAIN:** entered from RUN when `enable`=0. Counting continues with the current `n`.
  - At the wrap edge with `enable`=0: go to OFF, `clk_out`<=0, `ready`<=0.
  - At the wrap edge with `enable`=1: return to RUN seamlessly, with no gap and `n` reloaded.
  - `enable` toggling inside a period has no effect before the wrap.
- **Reset:** on any edge with `reset`=1, go to OFF; all counters 0; `n`=2; `clk_out`=0, `ready`=0, `period_strobe`=0.
  - `reset` overrides `enable`.
  - Reset mid-high-phase truncates the pulse; this is the only permitted runt.

## Timing
- Reset values: `clk_out`=0, `ready`=0, `period_strobe`=0.
- First `clk_out` rise: `SETTLE_CYCLES`+1 edges after the first edge sampling `enable`=1. `ready` rises on the same edge.
- Output period is exactly `n` input cycles; `clk_out` changes only on `clock` rising edges and is driven straight from a flop (no combinational gating).
- Ratio-change latency: the new `n` applies starting with the cycle after the next `period_strobe`.
- Stop latency: `clk_out`/`ready` fall at the first wrap edge after `enable` is sampled 0; worst case `n` cycles.
- Simultaneous wrap and `enable` fall in RUN: that wrap completes normally and the FSM enters DRAIN for one full further period.

## Test plan
- Reset/start: `reset` 3 cycles, `SETTLE_CYCLES`=64, `div`=4, raise `enable` → `clk_out`=0 for 65 edges, then pattern 1,1,0,0 repeating; `ready` rises with the first 1.
- Odd and saturated ratios: `div`=5 → high 2, low 3. `div`=0 and `div`=1 → period 2 (1,0). `div`=15 → high 7, low 8.
- Ratio change mid-period: running with `div`=4, set `div`=6 at `cnt`=1 → current period still 4 cycles; next period 3 high, 3 low; `period_strobe` spacing goes 4→6.
- Settle abort: drop `enable` at settle count 30, reassert → OFF, then a full 64-cycle settle restarts; no `clk_out` activity before it completes.
- Drain: `div`=6, drop `enable` at `cnt`=1 → period completes (3 high, 3 low), then `clk_out`=0 and `ready`=0. Re-raising `enable` before the wrap instead → continuous clock, no gap.
- Reset mid-operation: assert `reset` during a high phase with `div`=8 → next edge `clk_out`=0, `ready`=0, FSM in OFF. After release with `enable`=1, a full settle precedes output.
